// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: iterative RV32M DIV/DIVU/REM/REMU sequencer for the EX stage.
// Runs a 32-step radix-2 restoring division and stalls EX while it works.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_req               EX holds a valid divide this cycle
//   i_op                funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_a, i_b            forwarded dividend / divisor
//   i_flush             abort any operation (control hazard)
//   i_hold              EX pipeline register not advancing
//   o_stall             divide stall request to the hazard logic
//   o_busy              sequencer not idle
//   o_res_valid         o_res holds the result for the current request
//   o_res               quotient or remainder
module ex_div_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_flush,
    input  logic        i_hold,
    output logic        o_stall,
    output logic        o_busy,
    output logic        o_res_valid,
    output logic [31:0] o_res
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [31:0] r_res;
    logic        r_is_rem;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_signed;
    logic        w_ovf;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_spec;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic [31:0] w_quo_fin;
    logic [31:0] w_rem_fin;

    assign w_signed  = ~i_op[0];
    assign w_ovf     = w_signed & (i_a == 32'h8000_0000) & (i_b == 32'hFFFF_FFFF);
    assign w_abs_a   = (w_signed & i_a[31]) ? -i_a : i_a;
    assign w_abs_b   = (w_signed & i_b[31]) ? -i_b : i_b;
    assign w_spec    = (i_b == 32'd0) ? (i_op[1] ? i_a : 32'hFFFF_FFFF)
                                      : (i_op[1] ? 32'd0 : 32'h8000_0000);
    // 33-bit working remainder; no borrow out of the trial subtract means rem >= divisor
    assign w_rem_sh  = {r_rem, r_quo[31]};
    assign w_diff    = w_rem_sh - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[32];
    assign w_rem_nx  = w_ge ? w_diff[31:0] : w_rem_sh[31:0];
    assign w_quo_nx  = {r_quo[30:0], w_ge};
    assign w_quo_fin = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_rem_fin = r_neg_r ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_count  <= 5'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_dvs    <= 32'd0;
            r_res    <= 32'd0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (i_flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: if (i_req) begin
                    r_is_rem <= i_op[1];
                    r_neg_q  <= w_signed & (i_a[31] ^ i_b[31]);
                    r_neg_r  <= w_signed & i_a[31];
                    r_rem    <= 32'd0;
                    r_quo    <= w_abs_a;
                    r_dvs    <= w_abs_b;
                    if ((i_b == 32'd0) || w_ovf) begin
                        r_res   <= w_spec;
                        r_state <= DONE;
                    end else begin
                        r_count <= 5'd31;
                        r_state <= CALC;
                    end
                end
                CALC: if (!i_req) begin
                    r_state <= IDLE;
                end else begin
                    r_rem   <= w_rem_nx;
                    r_quo   <= w_quo_nx;
                    r_count <= r_count - 5'd1;
                    if (r_count == 5'd0) begin
                        r_res   <= r_is_rem ? w_rem_fin : w_quo_fin;
                        r_state <= DONE;
                    end
                end
                DONE: if (!i_hold) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_stall     = i_rst_n & i_req & (r_state != DONE) & ~i_flush;
    assign o_busy      = (r_state != IDLE);
    assign o_res_valid = (r_state == DONE);
    assign o_res       = r_res;
endmodule

// File: doc/ex_div_ctrl.md
# ex_div_ctrl

Iterative divide sequencer for the RV32M DIV/DIVU/REM/REMU instructions executing in the EX stage. It accepts forwarded operands when EX holds a divide, and stalls the pipeline while it runs a 32-step radix-2 restoring division. It applies the RISC-V divide-by-zero and overflow rules, then presents a registered result for the EX pipeline register. It sits beside the ALU, owns the EX stall request for divides, and obeys pipeline flush and hold.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- req  input  1  EX holds a valid divide instruction this cycle
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- a  input  32  dividend (post-forwarding rs1)
- b  input  32  divisor (post-forwarding rs2)
- flush  input  1  control-hazard flush of EX; aborts any operation
- hold  input  1  EX pipeline register not advancing (downstream stall)
- stall  output  1  divide stall request to the hazard logic
- busy  output  1  state is not IDLE
- res_valid  output  1  res holds the result for the current request
- res  output  32  quotient or remainder

## Operation
- States are IDLE, CALC and DONE.
- IDLE:
  - req & ~flush latches a, b, op, the sign flags and the special-case flags.
  - If b==0, go to DONE with the special result:
    - DIV/DIVU give 0xFFFFFFFF.
    - REM/REMU give a.
  - Signed overflow (op DIV/REM, a==0x80000000, b==0xFFFFFFFF) goes to DONE with DIV = 0x80000000 and REM = 0.
  - Otherwise go to CALC with count=31.
  - Signed ops use |a| and |b| as magnitudes; unsigned ops use raw values.
- CALC, once per cycle:
  - rem = {rem[31:0], quo[31]}; quo <<= 1.
  - If rem >= divisor, rem -= divisor and set quo[0].
  - rem is 33 bits wide.
  - count decrements; at count==0, go to DONE.
- CALC->DONE transition registers res:
  - Quotient is negated if the signs of a and b differ (signed ops).
  - Remainder is negated if a was negative (signed ops).
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
- DONE: res_valid=1. Stay while hold=1; go to IDLE when hold=0.
- stall = req & (state != DONE) & ~flush. stall is forced 0 while rst_n is low.
- busy = (state != IDLE).
- flush in any state: next state IDLE, res_valid drops, res unchanged. stall is 0 in the flush cycle.
- req deasserted in CALC without flush (squashed instruction): abort to IDLE next cycle.
- Operand changes after acceptance are ignored.
- res keeps its last value outside DONE. Only a transition into DONE updates it.

## Timing
- Reset values: state IDLE, count 0, res 0x00000000, res_valid 0, busy 0, stall 0.
- Normal op, req first seen at cycle 0 in IDLE:
  - CALC occupies cycles 1..32.
  - DONE is cycle 33, with res_valid=1 and stall=0.
  - stall is high for cycles 0..32 (33 cycles).
  - The EX register captures res at the end of cycle 33 if hold=0.
- Special case (b==0 or overflow): DONE at cycle 1; stall high only in cycle 0.
- Back-to-back divides: DONE -> IDLE, then the next req is accepted the following cycle. A one-cycle IDLE gap is required and stall stays high through it.
- Simultaneous flush & req in IDLE: no accept, stall 0.
- Simultaneous flush & hold in DONE: flush wins, go to IDLE.
- rst_n falling at any point (incl. mid-CALC) forces reset values immediately. Operation resumes from IDLE after release.

## Test plan
- DIVU a=100 b=7, hold=0:
  - stall high for 33 cycles.
  - res=14 with res_valid at cycle 33.
  - IDLE at cycle 34.
- REM a=0xFFFFFFF9 (-7), b=2: res=0xFFFFFFFF (-1). DIV with the same operands: res=0xFFFFFFFD (-3).
- DIV a=5 b=0: DONE at cycle 1, res=0xFFFFFFFF, stall only in cycle 0. REMU a=5 b=0: res=5.
- DIV a=0x80000000 b=0xFFFFFFFF: res=0x80000000 at cycle 1. REM with the same operands: res=0.
- DIVU 100/7 with flush at CALC cycle 10:
  - Next cycle is IDLE, res_valid=0, res unchanged, stall 0 in the flush cycle.
  - A new DIVU 9/3 accepted on the next cycle returns 3 after 33 cycles.
- DIVU 100/7 with hold=1 for 3 cycles entering DONE: res=14 held stable with res_valid=1 and stall=0 for 4 cycles, then IDLE. A second test drives rst_n low at CALC cycle 5: all outputs go to reset values immediately.
